serial_lut_db: RTL
==================

SERIAL_LUT_DB -- requirements
Module: serial_lut_db

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 4, meaning the select width, so the table depth is 2**IN_WIDTH entries.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 3, meaning the entry width in bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk, input, 1, rising-edge clock for all state.
REQ-004 rst_n, input, 1, asynchronous active-low reset.
REQ-005 d, input, 1, serial table data bit.
REQ-006 cs_n, input, 1, active-low shift enable for the shadow table.
REQ-007 commit_n, input, 1, active-low request to copy the shadow table into the active table.
REQ-008 rot_n, input, 1, active-low request to rotate the active table by one entry.
REQ-009 sel, input, IN_WIDTH, lookup index into the active table.
REQ-010 out, output, OUT_WIDTH, selected active-table entry.
REQ-011 full, output, 1, high when at least TBITS = 2**IN_WIDTH*OUT_WIDTH bits have been shifted since the last commit or reset.
REQ-012 commit_ack, output, 1, one-cycle pulse on a successful commit.
REQ-013 err, output, 1, one-cycle pulse on a rejected commit.

Function
REQ-014 The block SHALL hold two TBITS-wide registers: shadow (serial load) and active (lookup source).
REQ-015 Table layout: entry i SHALL be bits [(i+1)*OUT_WIDTH-1 : i*OUT_WIDTH]; on a cs_n-low edge, shadow <= {shadow[TBITS-2:0], d}, so the first bit loaded ends at the MSB of entry 2**IN_WIDTH-1.
REQ-016 A bit counter SHALL increment on each shift, saturate at TBITS, and drive full = (count == TBITS).
REQ-017 Shifting past full SHALL continue to shift, discarding the oldest bits; the count and full SHALL remain saturated.
REQ-018 Commit accepted: when commit_n is low, cs_n is high and full is 1, then active <= shadow, count <= 0 and commit_ack is 1 for the next cycle; shadow SHALL be kept unchanged.
REQ-019 Commit rejected: when commit_n is low with full at 0, or with cs_n low, then active is unchanged and err is 1 for the next cycle; any shift SHALL still occur.
REQ-020 A held commit_n SHALL commit only once, because count clears; further cycles reject and pulse err until full is reached again.
REQ-021 Rotate: when rot_n is low and no commit is accepted that cycle, active <= {active[OUT_WIDTH-1:0], active[TBITS-1:OUT_WIDTH]}, so entry i takes the old entry i+1 and entry 2**IN_WIDTH-1 takes the old entry 0.
REQ-022 A commit SHALL take priority over a rotate in the same cycle; a shift and a rotate in the same cycle SHALL both take effect, since they act on different registers.
REQ-023 Without the macro, out SHALL equal entry sel of active combinationally, with zero-cycle latency from sel and one cycle after a commit or rotate.

Reset
REQ-024 Asserting rst_n low SHALL clear shadow, active, count, full, commit_ack, err and any output register to 0 asynchronously, including mid-load.
REQ-025 After reset, out SHALL read 0 for every sel, and a load SHALL restart from a count of 0.

Configuration
REQ-026 Macro SERIAL_LUT_OUT_REG_EN: when defined, out SHALL be registered, giving one-cycle latency from sel, commit or rotate to out; when undefined, out SHALL follow REQ-023.
REQ-027 All other behaviour SHALL be identical with and without SERIAL_LUT_OUT_REG_EN.

Structure
REQ-028 Package serial_lut_pkg SHALL hold the default IN_WIDTH and OUT_WIDTH, a function for TBITS, and a function for the counter width, $clog2(TBITS+1).
REQ-029 The entry mux SHALL be the sub-module serial_lut_mux, which is purely combinational: sel plus table in, entry out.

Verification
REQ-030 Reset then shift 48 bits via cs_n, of which the first 3 are 1,0,1 and the rest 0; then commit -> full rises on the 48th shift; commit_ack pulses once; sel=15 gives out=3'b101 and every other sel gives out=0.
REQ-031 Commit after 47 bits -> err pulses; active is unchanged; on the 48th shift full=1, and a following commit succeeds.
REQ-032 After REQ-030, pulse rot_n for 1 cycle -> sel=14 gives 3'b101 and sel=15 gives 0; 15 more rotates return 3'b101 to sel=15.
REQ-033 commit_n and cs_n low together while full -> err pulses, no commit occurs, the shift occurs and full stays 1; commit_n and rot_n low together -> commit wins and no rotate occurs.
REQ-034 Assert rst_n mid-load after 20 bits -> all outputs are 0 immediately; a new 48-bit load is required before full is set.
REQ-035 With SERIAL_LUT_OUT_REG_EN defined, changing sel from 0 to 15 -> out updates one clk later; without it, out updates the same cycle.

Source files
------------

// File: rtl/serial_lut_pkg.sv
// serial_lut_pkg: shared sizing for the serially loaded lookup table.
// Holds default widths and helpers for table and counter sizes.
package serial_lut_pkg;

  localparam int DEF_IN_WIDTH  = 4;
  localparam int DEF_OUT_WIDTH = 3;

  function automatic int tbits(input int iw, input int ow);
    return (2 ** iw) * ow;
  endfunction

  function automatic int cnt_width(input int iw, input int ow);
    return $clog2(tbits(iw, ow) + 1);
  endfunction

endpackage

// File: rtl/serial_lut_mux.sv
// serial_lut_mux: combinational entry select from a packed table.
// Entry i occupies bits [(i+1)*OUT_WIDTH-1 : i*OUT_WIDTH].
import serial_lut_pkg::*;

module serial_lut_mux #(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]                     sel,
  input  logic [tbits(IN_WIDTH, OUT_WIDTH)-1:0]   tbl,
  output logic [OUT_WIDTH-1:0]                    entry
);

  always_comb begin
    entry = '0;
    for (int i = 0; i < 2 ** IN_WIDTH; i++) begin
      if (sel == IN_WIDTH'(i)) begin
        entry = tbl[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/serial_lut_db.sv
// serial_lut_db: double-buffered serial-load LUT with commit and rotate.
// Define SERIAL_LUT_OUT_REG_EN to register out (one cycle latency).
import serial_lut_pkg::*;

module serial_lut_db #(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 d,
  input  logic                 cs_n,
  input  logic                 commit_n,
  input  logic                 rot_n,
  input  logic [IN_WIDTH-1:0]  sel,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 full,
  output logic                 commit_ack,
  output logic                 err
);

  localparam int TBITS = tbits(IN_WIDTH, OUT_WIDTH);
  localparam int CW    = cnt_width(IN_WIDTH, OUT_WIDTH);
  localparam logic [CW-1:0] TMAX = CW'(TBITS);

  logic [TBITS-1:0]     shadow;
  logic [TBITS-1:0]     active;
  logic [CW-1:0]        count;
  logic [OUT_WIDTH-1:0] entry;
  logic                 shift;
  logic                 commit_req;
  logic                 commit_ok;

  assign shift      = ~cs_n;
  assign commit_req = ~commit_n;
  assign full       = (count == TMAX);
  // A commit needs a complete load and no shift in flight.
  assign commit_ok  = commit_req & cs_n & full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (shift) begin
      shadow <= {shadow[TBITS-2:0], d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (commit_ok) begin
      count <= '0;
    end else if (shift && !full) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
    end else if (commit_ok) begin
      active <= shadow;
    end else if (!rot_n) begin
      active <= {active[OUT_WIDTH-1:0],
                 active[TBITS-1:OUT_WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_ack <= 1'b0;
      err        <= 1'b0;
    end else begin
      commit_ack <= commit_ok;
      err        <= commit_req & ~commit_ok;
    end
  end

  serial_lut_mux #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_mux (
    .sel   (sel),
    .tbl   (active),
    .entry (entry)
  );

`ifdef SERIAL_LUT_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= entry;
    end
  end
`else
  assign out = entry;
`endif

endmodule
